ram_word_port_arbiter: RTL and testbench

RAM_WORD_PORT_ARBITER -- requirements
Module: ram_word_port_arbiter

---
 rtl/ram_word_port_arbiter_if.sv | 48 ++++
 rtl/ram_word_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_word_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_word_port_arbiter_if.sv
// Bundle of the two requester ports (A: bridge loader, B: core fetch) and
// the shared 16-bit RAM word port.
//   slave  : arbiter view (takes requests, drives the RAM port)
//   master : environment view (issues requests, models the RAM)
interface ram_word_port_arbiter_if #(
  parameter int unsigned ADDR_W = 26
) ();
  logic              a_rd;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_data;
  logic [15:0]       a_q;
  logic              a_busy;
  logic              a_done;

  logic              b_rd;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_data;
  logic [15:0]       b_q;
  logic              b_busy;
  logic              b_done;

  logic              word_rd;
  logic              word_wr;
  logic [ADDR_W-1:0] word_addr;
  logic [15:0]       word_data;
  logic [15:0]       word_q;
  logic              word_busy;

  modport slave (
    input  a_rd, a_wr, a_addr, a_data,
    output a_q, a_busy, a_done,
    input  b_rd, b_wr, b_addr, b_data,
    output b_q, b_busy, b_done,
    output word_rd, word_wr, word_addr, word_data,
    input  word_q, word_busy
  );

  modport master (
    output a_rd, a_wr, a_addr, a_data,
    input  a_q, a_busy, a_done,
    output b_rd, b_wr, b_addr, b_data,
    input  b_q, b_busy, b_done,
    input  word_rd, word_wr, word_addr, word_data,
    output word_q, word_busy
  );
endinterface

// File: rtl/ram_word_port_arbiter.sv
// Two-port arbiter in front of a single 16-bit word RAM port.
// Each requester has one pending slot; A wins ties, but after A_STREAK_MAX
// consecutive A grants with B waiting, B is served.
// Ports:
//   clk_sys : clock, rising edge
//   reset   : asynchronous active-high reset
//   bus     : ram_word_port_arbiter_if.slave (A/B request ports, RAM port)
// word_rd/word_wr are decoded from the ISSUE state and word_busy so that the
// strobe sits exactly in the ISSUE cycle that actually launches the access.
module ram_word_port_arbiter #(
  parameter int unsigned ADDR_W       = 26,
  parameter int unsigned A_STREAK_MAX = 4
) (
  input logic                    clk_sys,
  input logic                    reset,
  ram_word_port_arbiter_if.slave bus
);

  localparam int unsigned STREAK_W = (A_STREAK_MAX < 1) ? 1 : $clog2(A_STREAK_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } slot_t;

  state_t              state_q, state_d;
  slot_t               slot_a_q, slot_b_q;
  logic                pend_a_q, pend_b_q;
  logic                gnt_b_q;
  logic                cur_wr_q;
  logic [STREAK_W-1:0] streak_q;
  logic                a_done_q, b_done_q;
  logic [15:0]         a_q_q, b_q_q;
  logic [ADDR_W-1:0]   word_addr_q;
  logic [15:0]         word_data_q;

  logic grant_c, grant_b_c, issue_c, capture_c, finish_c;
  logic a_take_c, b_take_c, streak_max_c;

  assign streak_max_c = (streak_q == STREAK_W'(A_STREAK_MAX));

  // A slot frees up in its DONE cycle, so a new pulse then is taken too
  assign a_take_c = (bus.a_rd | bus.a_wr) & (~pend_a_q | (finish_c & ~gnt_b_q));
  assign b_take_c = (bus.b_rd | bus.b_wr) & (~pend_b_q | (finish_c &  gnt_b_q));

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, grant decision and per-state strobes
  always_comb begin
    state_d   = state_q;
    grant_c   = 1'b0;
    grant_b_c = 1'b0;
    issue_c   = 1'b0;
    capture_c = 1'b0;
    finish_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_a_q | pend_b_q) begin
          grant_c   = 1'b1;
          grant_b_c = pend_b_q & (~pend_a_q | streak_max_c);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.word_busy) begin
          issue_c = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (!bus.word_busy) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        finish_c = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending slots; read wins when rd and wr pulse together
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      slot_a_q <= '0;
      slot_b_q <= '0;
    end else begin
      if (a_take_c) begin
        pend_a_q <= 1'b1;
        slot_a_q <= '{wr: bus.a_wr & ~bus.a_rd, addr: bus.a_addr, data: bus.a_data};
      end else if (finish_c && !gnt_b_q) begin
        pend_a_q <= 1'b0;
      end
      if (b_take_c) begin
        pend_b_q <= 1'b1;
        slot_b_q <= '{wr: bus.b_wr & ~bus.b_rd, addr: bus.b_addr, data: bus.b_data};
      end else if (finish_c && gnt_b_q) begin
        pend_b_q <= 1'b0;
      end
    end
  end

  // Grant bookkeeping and A-streak fairness counter
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      gnt_b_q     <= 1'b0;
      cur_wr_q    <= 1'b0;
      streak_q    <= '0;
      word_addr_q <= '0;
      word_data_q <= '0;
    end else begin
      if (grant_c) begin
        gnt_b_q     <= grant_b_c;
        cur_wr_q    <= grant_b_c ? slot_b_q.wr   : slot_a_q.wr;
        word_addr_q <= grant_b_c ? slot_b_q.addr : slot_a_q.addr;
        word_data_q <= grant_b_c ? slot_b_q.data : slot_a_q.data;
      end
      if (!pend_b_q || (grant_c && grant_b_c))
        streak_q <= '0;
      else if (grant_c && !streak_max_c)
        streak_q <= streak_q + STREAK_W'(1);
    end
  end

  // Read data capture and completion pulses
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      a_q_q    <= '0;
      b_q_q    <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      a_done_q <= capture_c & ~gnt_b_q;
      b_done_q <= capture_c &  gnt_b_q;
      if (capture_c && !cur_wr_q) begin
        if (gnt_b_q) b_q_q <= bus.word_q;
        else         a_q_q <= bus.word_q;
      end
    end
  end

  assign bus.a_q       = a_q_q;
  assign bus.b_q       = b_q_q;
  assign bus.a_busy    = pend_a_q;
  assign bus.b_busy    = pend_b_q;
  assign bus.a_done    = a_done_q;
  assign bus.b_done    = b_done_q;
  assign bus.word_rd   = issue_c & ~cur_wr_q;
  assign bus.word_wr   = issue_c &  cur_wr_q;
  assign bus.word_addr = word_addr_q;
  assign bus.word_data = word_data_q;

endmodule

// File: tb/tb_ram_word_port_arbiter.sv
// Self-checking bench for ram_word_port_arbiter: vector table for single
// transactions plus hand sequences for contention, fairness, stalls,
// ignored requests and reset mid-transaction. RAM strobes are checked
// against a scoreboard queue filled when requests are driven.
module tb_ram_word_port_arbiter;

  localparam int unsigned AW = 26;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  ram_word_port_arbiter_if #(.ADDR_W(AW)) bus ();

  ram_word_port_arbiter #(.ADDR_W(AW), .A_STREAK_MAX(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic          pb;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [15:0]   ramq;
  } vec_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          chk_data;
  } sb_t;

  int   total = 0;
  int   bad = 0;
  int   strobe_cnt = 0;
  int   a_done_cnt = 0;
  int   b_done_cnt = 0;
  logic sb_en = 1'b1;
  sb_t  sbq[$];
  logic [15:0] exp_aq = '0;
  logic [15:0] exp_bq = '0;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_sb(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [15:0] data);
    sb_t e;
    e.wr       = wr & ~rd;
    e.addr     = addr;
    e.data     = data;
    e.chk_data = wr & ~rd;
    sbq.push_back(e);
  endtask

  task automatic drive_req(input logic pb, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [15:0] data);
    if (pb) begin
      bus.b_rd = rd; bus.b_wr = wr; bus.b_addr = addr; bus.b_data = data;
    end else begin
      bus.a_rd = rd; bus.a_wr = wr; bus.a_addr = addr; bus.a_data = data;
    end
  endtask

  task automatic clear_req();
    bus.a_rd = 1'b0; bus.a_wr = 1'b0; bus.b_rd = 1'b0; bus.b_wr = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((bus.a_busy || bus.b_busy) && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.a_busy | bus.b_busy), 32'd0);
  endtask

  // One isolated transaction with word_busy low: latency, q and busy checks
  task automatic run_vec(input vec_t v, input string nm);
    int   n;
    logic dn;
    bus.word_q = v.ramq;
    drive_req(v.pb, v.rd, v.wr, v.addr, v.data);
    push_sb(v.rd, v.wr, v.addr, v.data);
    tick();
    clear_req();
    n = 1;
    chk({nm, "_busy"}, 32'(v.pb ? bus.b_busy : bus.a_busy), 32'd1);
    dn = 1'b0;
    while (!dn && n < 30) begin
      tick();
      n++;
      dn = v.pb ? bus.b_done : bus.a_done;
    end
    chk({nm, "_lat"}, 32'(n), 32'd5);
    if (v.rd) begin
      if (v.pb) exp_bq = v.ramq;
      else      exp_aq = v.ramq;
    end
    chk({nm, "_aq"}, 32'(bus.a_q), 32'(exp_aq));
    chk({nm, "_bq"}, 32'(bus.b_q), 32'(exp_bq));
    tick();
    chk({nm, "_idle"}, 32'(v.pb ? bus.b_busy : bus.a_busy), 32'd0);
  endtask

  // RAM-side monitor: every strobe cycle is checked against the scoreboard
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (bus.a_done) a_done_cnt++;
      if (bus.b_done) b_done_cnt++;
      if (bus.word_rd || bus.word_wr) begin
        strobe_cnt++;
        chk("rd_wr_excl", 32'(bus.word_rd & bus.word_wr), 32'd0);
        if (sb_en) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
          end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("sb_dir", 32'(bus.word_wr), 32'(e.wr));
            chk("sb_addr", 32'(bus.word_addr), 32'(e.addr));
            if (e.chk_data) chk("sb_data", 32'(bus.word_data), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n, sc0, ad0, bd0, a_grants;
    logic        a_seen, got_b;
    logic [31:0] mask;

    vecs[0] = '{pb:1'b0, rd:1'b1, wr:1'b0, addr:26'h0000100, data:16'h0000, ramq:16'hBEEF};
    vecs[1] = '{pb:1'b0, rd:1'b0, wr:1'b1, addr:26'h0000200, data:16'h1234, ramq:16'h5555};
    vecs[2] = '{pb:1'b1, rd:1'b1, wr:1'b0, addr:26'h3FFFFFF, data:16'h0000, ramq:16'hCAFE};
    vecs[3] = '{pb:1'b1, rd:1'b0, wr:1'b1, addr:26'h0000000, data:16'hFFFF, ramq:16'hAAAA};
    vecs[4] = '{pb:1'b0, rd:1'b1, wr:1'b1, addr:26'h0000055, data:16'h9999, ramq:16'h0F0F};
    vecs[5] = '{pb:1'b1, rd:1'b1, wr:1'b0, addr:26'h0000123, data:16'h0000, ramq:16'h0000};
    vecs[6] = '{pb:1'b0, rd:1'b1, wr:1'b0, addr:26'h2AAAAAA, data:16'h0000, ramq:16'h8001};

    clear_req();
    bus.a_addr = '0; bus.a_data = '0; bus.b_addr = '0; bus.b_data = '0;
    bus.word_q = '0; bus.word_busy = 1'b0;

    tick();
    tick();
    chk("rst_a_busy", 32'(bus.a_busy), 32'd0);
    chk("rst_b_busy", 32'(bus.b_busy), 32'd0);
    chk("rst_strobe", 32'(bus.word_rd | bus.word_wr), 32'd0);
    chk("rst_waddr", 32'(bus.word_addr), 32'd0);
    chk("rst_done", 32'(bus.a_done | bus.b_done), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    chk("vec_strobes", 32'(strobe_cnt), 32'd6);

    // Simultaneous writes: A first, B after a_done
    sc0 = strobe_cnt;
    drive_req(1'b0, 1'b0, 1'b1, 26'h0000300, 16'hAAAA);
    drive_req(1'b1, 1'b0, 1'b1, 26'h0000301, 16'hBBBB);
    push_sb(1'b0, 1'b1, 26'h0000300, 16'hAAAA);
    push_sb(1'b0, 1'b1, 26'h0000301, 16'hBBBB);
    tick();
    clear_req();
    a_seen = 1'b0; got_b = 1'b0; n = 0;
    while (!got_b && n < 60) begin
      tick();
      n++;
      if (bus.a_done) a_seen = 1'b1;
      if (bus.b_done) got_b = 1'b1;
    end
    chk("both_b_done", 32'(got_b), 32'd1);
    chk("both_a_first", 32'(a_seen), 32'd1);
    chk("both_strobes", 32'(strobe_cnt - sc0), 32'd2);
    wait_idle("both_idle");

    // Fairness: A re-requests on every a_done while B waits
    sb_en = 1'b0;
    a_grants = 0; got_b = 1'b0; n = 0;
    drive_req(1'b0, 1'b1, 1'b0, 26'h0000010, 16'h0);
    drive_req(1'b1, 1'b1, 1'b0, 26'h0000020, 16'h0);
    tick();
    clear_req();
    while (!got_b && n < 300) begin
      tick();
      n++;
      bus.a_rd = 1'b0;
      if (bus.b_done) got_b = 1'b1;
      else if (bus.a_done) begin
        a_grants++;
        drive_req(1'b0, 1'b1, 1'b0, 26'(32'h10 + 32'(a_grants)), 16'h0);
      end
    end
    bus.a_rd = 1'b0;
    chk("fair_b_done", 32'(got_b), 32'd1);
    chk("fair_a_grants", 32'(a_grants), 32'd4);
    wait_idle("fair_idle");
    exp_aq = bus.word_q; exp_bq = bus.word_q;
    sb_en = 1'b1;

    // word_busy stalls in ISSUE and in WAIT
    sc0 = strobe_cnt; ad0 = a_done_cnt;
    bus.word_busy = 1'b1;
    drive_req(1'b0, 1'b1, 1'b0, 26'h0000777, 16'h0);
    push_sb(1'b1, 1'b0, 26'h0000777, 16'h0);
    tick();
    clear_req();
    repeat (12) tick();
    chk("stall_issue_nostrobe", 32'(strobe_cnt - sc0), 32'd0);
    bus.word_busy = 1'b0;
    tick();
    bus.word_busy = 1'b1;
    chk("stall_one_strobe", 32'(strobe_cnt - sc0), 32'd1);
    repeat (10) tick();
    chk("stall_wait_nodone", 32'(a_done_cnt - ad0), 32'd0);
    bus.word_q = 16'h7777;
    bus.word_busy = 1'b0;
    tick();
    chk("stall_done", 32'(bus.a_done), 32'd1);
    chk("stall_q", 32'(bus.a_q), 32'h7777);
    exp_aq = 16'h7777;
    repeat (5) tick();
    chk("stall_done_once", 32'(a_done_cnt - ad0), 32'd1);
    chk("stall_strobes", 32'(strobe_cnt - sc0), 32'd1);

    // Second pulse while busy is ignored
    sc0 = strobe_cnt; ad0 = a_done_cnt;
    bus.word_q = 16'h4321;
    drive_req(1'b0, 1'b1, 1'b0, 26'h0000400, 16'h0);
    push_sb(1'b1, 1'b0, 26'h0000400, 16'h0);
    tick();
    clear_req();
    tick();
    drive_req(1'b0, 1'b1, 1'b0, 26'h0000401, 16'h0);
    tick();
    clear_req();
    repeat (12) tick();
    chk("ign_strobes", 32'(strobe_cnt - sc0), 32'd1);
    chk("ign_dones", 32'(a_done_cnt - ad0), 32'd1);
    chk("ign_q", 32'(bus.a_q), 32'h4321);
    chk("ign_busy", 32'(bus.a_busy), 32'd0);
    exp_aq = 16'h4321;

    // Reset while in WAIT
    ad0 = a_done_cnt;
    bus.word_q = 16'h1111;
    drive_req(1'b0, 1'b1, 1'b0, 26'h0000500, 16'h0);
    push_sb(1'b1, 1'b0, 26'h0000500, 16'h0);
    tick();
    clear_req();
    tick();
    tick();
    bus.word_busy = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    mask = {12'(bus.a_q), 12'(bus.word_addr), 2'(bus.a_busy), 2'(bus.a_done),
            2'(bus.word_rd), 2'(bus.word_wr)};
    chk("rst_wait_outputs", mask, 32'd0);
    tick();
    reset = 1'b0;
    exp_aq = '0; exp_bq = '0;
    repeat (3) tick();
    bus.word_busy = 1'b0;
    repeat (10) tick();
    chk("rst_no_done", 32'(a_done_cnt - ad0), 32'd0);
    chk("rst_sb_drained", 32'(sbq.size()), 32'd0);
    run_vec(vecs[6], "post_rst");

    chk("sb_empty_end", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
